can_sff_tx: RTL and testbench

- Serial CAN 2.0A standard-frame (11-bit ID) transmitter.
- It is the transmit-side counterpart to the controller's rx0 receive path.
- A host loads an 11-byte transmit buffer using the controller's byte-wide write style, then issues start. The block serializes SOF through IFS onto tx0 with bit stuffing and CRC-15.
- It samples rx0 to detect arbitration loss and a missing ACK.
- It is used both as a bus-frame generator in benches and as the controller's transmit engine.

---
 rtl/can_sff_tx_pkg.sv | 50 +++++
 rtl/can_sff_tx_if.sv | 27 ++
 rtl/can_crc15.sv | 28 ++
 rtl/can_sff_tx.sv | 177 +++++++++++++++++
 tb/tb_can_sff_tx.sv | 236 +++++++++++++++++++++++
 5 files changed

// File: rtl/can_sff_tx_pkg.sv
// can_sff_tx_pkg -- shared constants, FSM encoding and helpers for the CAN 2.0A transmitter (rev 1.0)
`default_nettype none

package can_sff_tx_pkg;

  localparam logic [14:0] CAN_CRC15_POLY = 15'h4599;

  localparam logic [6:0] ARB_LEN  = 7'd12;
  localparam logic [6:0] CTRL_LEN = 7'd6;
  localparam logic [6:0] CRC_LEN  = 7'd15;
  localparam logic [6:0] EOF_LEN  = 7'd7;
  localparam logic [6:0] IFS_LEN  = 7'd3;

  localparam logic [6:0] ARB_LAST  = ARB_LEN  - 7'd1;
  localparam logic [6:0] CTRL_LAST = CTRL_LEN - 7'd1;
  localparam logic [6:0] CRC_LAST  = CRC_LEN  - 7'd1;
  localparam logic [6:0] EOF_LAST  = EOF_LEN  - 7'd1;
  localparam logic [6:0] IFS_LAST  = IFS_LEN  - 7'd1;

  typedef logic [3:0] tx_state_t;

  localparam tx_state_t ST_IDLE     = 4'd0;
  localparam tx_state_t ST_SOF      = 4'd1;
  localparam tx_state_t ST_ARB      = 4'd2;
  localparam tx_state_t ST_CTRL     = 4'd3;
  localparam tx_state_t ST_DATA     = 4'd4;
  localparam tx_state_t ST_CRC      = 4'd5;
  localparam tx_state_t ST_CRC_DEL  = 4'd6;
  localparam tx_state_t ST_ACK_SLOT = 4'd7;
  localparam tx_state_t ST_ACK_DEL  = 4'd8;
  localparam tx_state_t ST_EOF      = 4'd9;
  localparam tx_state_t ST_IFS      = 4'd10;

  // Fields SOF through CRC are subject to bit stuffing (encoding is ordered).
  function automatic logic is_stuffed(input tx_state_t s);
    return (s >= ST_SOF) && (s <= ST_CRC);
  endfunction

  function automatic logic [6:0] data_bits(input logic rtr, input logic [3:0] dlc);
    if (rtr)
      return 7'd0;
    else if (dlc > 4'd8)
      return 7'd64;
    else
      return {dlc, 3'b000};
  endfunction

endpackage

`default_nettype wire

// File: rtl/can_sff_tx_if.sv
// can_sff_tx_if -- host buffer/command and bus signals of the CAN transmitter (rev 1.0)
`default_nettype none

interface can_sff_tx_if;
  logic       val;
  logic [3:0] address;
  logic [7:0] wdata;
  logic       start;
  logic       rx0;
  logic       tx0;
  logic       busy;
  logic       done;
  logic       ack_err;
  logic       arb_lost;

  modport master (
    output val, address, wdata, start, rx0,
    input  tx0, busy, done, ack_err, arb_lost
  );

  modport slave (
    input  val, address, wdata, start, rx0,
    output tx0, busy, done, ack_err, arb_lost
  );
endinterface

`default_nettype wire

// File: rtl/can_crc15.sv
// can_crc15 -- serial CRC-15 LFSR for CAN frames, shared by transmit and receive paths (rev 1.0)
`default_nettype none

module can_crc15
  import can_sff_tx_pkg::*;
(
  input  wire logic        clk,
  input  wire logic        rst,
  input  wire logic        clr,
  input  wire logic        en,
  input  wire logic        din,
  output logic      [14:0] crc
);

  logic w_fb;

  assign w_fb = din ^ crc[14];

  always_ff @(posedge clk) begin
    if (rst || clr)
      crc <= '0;
    else if (en)
      crc <= {crc[13:0], 1'b0} ^ (w_fb ? CAN_CRC15_POLY : 15'h0000);
  end

endmodule

`default_nettype wire

// File: rtl/can_sff_tx.sv
// can_sff_tx -- CAN 2.0A standard-frame serial transmitter with stuffing, CRC-15,
// arbitration-loss and ACK monitoring (rev 1.0)
`default_nettype none

module can_sff_tx
  import can_sff_tx_pkg::*;
#(
  parameter int BIT_CYCLES   = 40,
  parameter int SAMPLE_POINT = 28
) (
  input  wire logic   xtal1,
  input  wire logic   rst,
  can_sff_tx_if.slave bus
);

  localparam int TW = $clog2(BIT_CYCLES);
  localparam logic [TW-1:0] c_t_last   = TW'(BIT_CYCLES - 1);
  localparam logic [TW-1:0] c_t_sample = TW'(SAMPLE_POINT);

  logic [7:0]    r_buf [0:10];
  tx_state_t     r_state, w_state_nxt, w_adv_state;
  logic [6:0]    r_cnt, w_cnt_nxt, w_adv_cnt;
  logic          r_stuff, w_stuff_nxt;
  logic [2:0]    r_run, w_run_nxt;
  logic          r_tx, w_tx_nxt;
  logic [TW-1:0] r_timer;
  logic          r_rx_s;
  logic          r_ack_err;

  logic          w_busy, w_bound, w_start, w_rx_bit, w_arb_lost;
  logic          w_adv_bit, w_crc_en;
  logic [14:0]   w_crc;
  logic [10:0]   w_id;
  logic [63:0]   w_data;
  logic [6:0]    w_ndata;
  logic          w_rtr;
  logic [3:0]    w_dlc;
  logic          w_unused_bits;

  assign w_id     = {r_buf[1], r_buf[2][7:5]};
  assign w_rtr    = r_buf[0][6];
  assign w_dlc    = r_buf[0][3:0];
  assign w_data   = {r_buf[3], r_buf[4], r_buf[5], r_buf[6],
                     r_buf[7], r_buf[8], r_buf[9], r_buf[10]};
  assign w_ndata  = data_bits(w_rtr, w_dlc);
  assign w_unused_bits = ^{r_buf[0][7], r_buf[0][5:4], r_buf[2][4:0]};

  assign w_busy     = (r_state != ST_IDLE);
  assign w_bound    = w_busy && (r_timer == c_t_last);
  assign w_start    = bus.start && !w_busy;
  // With the sample point on the last cycle the registered copy is not yet valid.
  assign w_rx_bit   = (r_timer == c_t_sample) ? bus.rx0 : r_rx_s;
  assign w_arb_lost = w_bound && (r_state == ST_ARB) && r_tx && !w_rx_bit;

  can_crc15 u_crc (
    .clk (xtal1),
    .rst (rst),
    .clr (w_start),
    .en  (w_crc_en),
    .din (w_adv_bit),
    .crc (w_crc)
  );

  always_ff @(posedge xtal1) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_stuff <= 1'b0;
      r_run   <= '0;
      r_tx    <= 1'b1;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_stuff <= w_stuff_nxt;
      r_run   <= w_run_nxt;
      r_tx    <= w_tx_nxt;
    end
  end

  always_ff @(posedge xtal1) begin
    if (rst) begin
      r_timer   <= '0;
      r_rx_s    <= 1'b1;
      r_ack_err <= 1'b0;
      for (int i = 0; i < 11; i++) r_buf[i] <= '0;
    end else begin
      r_timer <= (w_busy && !w_bound) ? r_timer + 1'b1 : '0;
      if (w_busy && (r_timer == c_t_sample))
        r_rx_s <= bus.rx0;
      if (w_start)
        r_ack_err <= 1'b0;
      else if (w_bound && (r_state == ST_ACK_SLOT) && w_rx_bit)
        r_ack_err <= 1'b1;
      if (bus.val && !w_busy && (bus.address <= 4'd10))
        r_buf[bus.address] <= bus.wdata;
    end
  end

  // (r_state, r_cnt) name the last field bit sent; r_stuff marks a stuff bit on the bus.
  always_comb begin
    w_adv_state = r_state;
    w_adv_cnt   = r_cnt + 7'd1;
    w_adv_bit   = 1'b1;
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_stuff_nxt = r_stuff;
    w_tx_nxt    = r_tx;
    w_run_nxt   = r_run;
    w_crc_en    = 1'b0;

    case (r_state)
      ST_SOF:      begin w_adv_state = ST_ARB; w_adv_cnt = '0; end
      ST_ARB:      if (r_cnt == ARB_LAST) begin w_adv_state = ST_CTRL; w_adv_cnt = '0; end
      ST_CTRL:     if (r_cnt == CTRL_LAST) begin
                     w_adv_state = (w_ndata == 7'd0) ? ST_CRC : ST_DATA;
                     w_adv_cnt   = '0;
                   end
      ST_DATA:     if (r_cnt == w_ndata - 7'd1) begin w_adv_state = ST_CRC; w_adv_cnt = '0; end
      ST_CRC:      if (r_cnt == CRC_LAST) begin w_adv_state = ST_CRC_DEL; w_adv_cnt = '0; end
      ST_CRC_DEL:  begin w_adv_state = ST_ACK_SLOT; w_adv_cnt = '0; end
      ST_ACK_SLOT: begin w_adv_state = ST_ACK_DEL; w_adv_cnt = '0; end
      ST_ACK_DEL:  begin w_adv_state = ST_EOF; w_adv_cnt = '0; end
      ST_EOF:      if (r_cnt == EOF_LAST) begin w_adv_state = ST_IFS; w_adv_cnt = '0; end
      ST_IFS:      if (r_cnt == IFS_LAST) begin w_adv_state = ST_IDLE; w_adv_cnt = '0; end
      default:     begin w_adv_state = ST_IDLE; w_adv_cnt = '0; end
    endcase

    case (w_adv_state)
      ST_ARB:  w_adv_bit = (w_adv_cnt == ARB_LAST) ? w_rtr : w_id[4'(7'd10 - w_adv_cnt)];
      ST_CTRL: w_adv_bit = (w_adv_cnt < 7'd2) ? 1'b0 : w_dlc[2'(7'd5 - w_adv_cnt)];
      ST_DATA: w_adv_bit = w_data[6'(7'd63 - w_adv_cnt)];
      ST_CRC:  w_adv_bit = w_crc[4'(7'd14 - w_adv_cnt)];
      default: w_adv_bit = 1'b1;
    endcase

    if (!w_busy) begin
      if (w_start) begin
        w_state_nxt = ST_SOF;
        w_cnt_nxt   = '0;
        w_stuff_nxt = 1'b0;
        w_tx_nxt    = 1'b0;
        w_run_nxt   = 3'd1;
      end
    end else if (w_bound) begin
      if (w_arb_lost) begin
        w_state_nxt = ST_IDLE;
        w_cnt_nxt   = '0;
        w_stuff_nxt = 1'b0;
        w_tx_nxt    = 1'b1;
        w_run_nxt   = '0;
      end else if (is_stuffed(r_state) && (r_run == 3'd5)) begin
        w_stuff_nxt = 1'b1;
        w_tx_nxt    = ~r_tx;
        w_run_nxt   = 3'd1;
      end else begin
        w_state_nxt = w_adv_state;
        w_cnt_nxt   = w_adv_cnt;
        w_stuff_nxt = 1'b0;
        w_tx_nxt    = w_adv_bit;
        w_run_nxt   = (w_adv_bit == r_tx) ? r_run + 3'd1 : 3'd1;
        w_crc_en    = (w_adv_state == ST_ARB) || (w_adv_state == ST_CTRL) ||
                      (w_adv_state == ST_DATA);
      end
    end
  end

  always_comb begin
    bus.tx0      = r_tx;
    bus.busy     = w_busy;
    bus.done     = w_bound && (r_state == ST_IFS) && (r_cnt == IFS_LAST);
    bus.arb_lost = w_arb_lost;
    bus.ack_err  = r_ack_err;
  end

endmodule

`default_nettype wire

// File: tb/tb_can_sff_tx.sv
// tb_can_sff_tx -- randomized and directed bench for can_sff_tx against a frame-level model
`default_nettype none
`timescale 1ns/1ps

module tb_can_sff_tx;

  localparam int BC = 40;

  logic clk = 1'b0;
  logic rst = 1'b1;

  can_sff_tx_if bus();

  can_sff_tx #(.BIT_CYCLES(BC), .SAMPLE_POINT(28)) dut (
    .xtal1 (clk),
    .rst   (rst),
    .bus   (bus)
  );

  always #25 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  int total = 0;
  int bad   = 0;

  bit [7:0]  mbuf [11];
  bit        exp_bits[$];
  int        ack_idx  = 0;
  int        n_crc_in = 0;
  int        t0       = 0;
  int        abort_k  = -1;
  int        busy_cnt = 0;
  bit [14:0] m_crc;
  bit        chk_on   = 1'b0;
  bit        ack_ok   = 1'b1;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Frame as it must appear on the bus, one entry per bit time.
  function automatic void build_frame();
    bit raw[$];
    bit [14:0] c;
    bit nxt, last;
    int run, dlc, ndata;
    raw.delete();
    exp_bits.delete();
    raw.push_back(1'b0);
    for (int i = 7; i >= 0; i--) raw.push_back(mbuf[1][i]);
    for (int i = 7; i >= 5; i--) raw.push_back(mbuf[2][i]);
    raw.push_back(mbuf[0][6]);
    raw.push_back(1'b0);
    raw.push_back(1'b0);
    for (int i = 3; i >= 0; i--) raw.push_back(mbuf[0][i]);
    dlc   = int'(mbuf[0][3:0]);
    ndata = mbuf[0][6] ? 0 : ((dlc > 8) ? 8 : dlc);
    for (int b = 0; b < ndata; b++)
      for (int i = 7; i >= 0; i--) raw.push_back(mbuf[3+b][i]);
    c = '0;
    foreach (raw[i]) begin
      nxt = raw[i] ^ c[14];
      c   = {c[13:0], 1'b0};
      if (nxt) c = c ^ 15'h4599;
    end
    n_crc_in = raw.size();
    m_crc    = c;
    for (int i = 14; i >= 0; i--) raw.push_back(c[i]);
    run  = 0;
    last = 1'b1;
    foreach (raw[i]) begin
      exp_bits.push_back(raw[i]);
      if (raw[i] == last) run++;
      else begin run = 1; last = raw[i]; end
      if (run == 5) begin
        exp_bits.push_back(!last);
        last = !last;
        run  = 1;
      end
    end
    ack_idx = exp_bits.size() + 1;
    repeat (13) exp_bits.push_back(1'b1);
  endfunction

  always @(negedge clk) begin : cmp
    int rel, k, ph, lim;
    bit [4:0] e, a;
    if (chk_on) begin
      rel  = cyc - t0;
      k    = rel / BC;
      ph   = rel % BC;
      lim  = (abort_k >= 0) ? abort_k + 1 : exp_bits.size();
      e[4] = (k < lim) ? exp_bits[k] : 1'b1;
      e[3] = (k < lim);
      e[2] = (abort_k < 0) && (k == lim - 1) && (ph == BC - 1);
      e[1] = (abort_k >= 0) && (k == abort_k) && (ph == BC - 1);
      e[0] = (abort_k < 0) && !ack_ok && (k > ack_idx);
      a    = {bus.tx0, bus.busy, bus.done, bus.arb_lost, bus.ack_err};
      if (bus.busy) busy_cnt++;
      total++;
      if (a !== e) begin
        bad++;
        $display("FAIL bus bit=%0d phase=%0d: tx/busy/done/arb/ack got %b expected %b", k, ph, a, e);
      end
    end
  end

  // Bus echo: rx0 follows tx0 except where another node drives dominant.
  initial begin : rxdrv
    int kk;
    bus.rx0 = 1'b1;
    forever begin
      @(negedge clk);
      kk = (cyc - t0) / BC;
      if (chk_on && ack_ok && (abort_k < 0) && (kk == ack_idx))
        bus.rx0 = 1'b0;
      else if (chk_on && (abort_k >= 0) && (kk == abort_k))
        bus.rx0 = 1'b0;
      else
        bus.rx0 = bus.tx0;
    end
  end

  task automatic wr(input int a, input int d);
    @(negedge clk);
    bus.val     = 1'b1;
    bus.address = a[3:0];
    bus.wdata   = d[7:0];
    if (a <= 10) mbuf[a] = d[7:0];
    @(negedge clk);
    bus.val = 1'b0;
  endtask

  task automatic kick();
    @(negedge clk);
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    t0        = cyc;
    busy_cnt  = 0;
    chk_on    = 1'b1;
  endtask

  task automatic run_frame(input bit ack, input int abrt);
    int lim;
    build_frame();
    ack_ok  = ack;
    abort_k = abrt;
    kick();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      bus.val     = 1'b1;
      bus.address = 4'($urandom_range(0, 10));
      bus.wdata   = 8'($urandom);
    end
    @(negedge clk);
    bus.val = 1'b0;
    lim = (abrt >= 0) ? abrt + 1 : exp_bits.size();
    repeat ((lim + 2) * BC - 4) @(negedge clk);
    chk_on = 1'b0;
    if (abrt < 0) check("busy_len", busy_cnt, exp_bits.size() * BC);
  endtask

  initial begin : main
    bit [21:0] pre, got;
    bus.val = 1'b0; bus.address = '0; bus.wdata = '0; bus.start = 1'b0;
    foreach (mbuf[i]) mbuf[i] = '0;
    repeat (3) @(negedge clk);
    check("reset_outs", int'({bus.tx0, bus.busy, bus.done, bus.arb_lost, bus.ack_err}), 5'b10000);
    rst = 1'b0;

    // Frame with ID 0, DLC 8, data 01..08; also a write to an unused address.
    wr(0, 'h08); wr(1, 'h00); wr(2, 'h00);
    for (int i = 0; i < 8; i++) wr(3 + i, i + 1);
    wr(11, 'hAA);
    build_frame();
    pre = 22'b0000010000010000011000;
    for (int i = 0; i < 22; i++) got[21-i] = exp_bits[i];
    check("stuff_prefix", int'(got), int'(pre));
    run_frame(1'b1, -1);
    check("ack_err_acked", bus.ack_err, 0);

    run_frame(1'b0, -1);
    check("ack_err_sticky", bus.ack_err, 1);

    // ID 0x7FF, another node wins on ID10.
    wr(1, 'hFF); wr(2, 'hE0);
    run_frame(1'b1, 1);
    check("arb_idle", bus.busy, 0);

    // Remote frame, DLC 4.
    wr(0, 'h44); wr(1, int'($urandom)); wr(2, int'($urandom));
    build_frame();
    check("rtr_crc_bits", n_crc_in, 19);
    run_frame(1'b1, -1);

    // Reset in the middle of DATA.
    wr(0, 'h08); wr(1, 'h00); wr(2, 'h00);
    build_frame();
    ack_ok  = 1'b1;
    abort_k = -1;
    kick();
    repeat (30 * BC) @(negedge clk);
    chk_on = 1'b0;
    rst    = 1'b1;
    @(posedge clk);
    #1;
    check("rst_tx0", bus.tx0, 1);
    check("rst_busy", bus.busy, 0);
    @(negedge clk);
    rst = 1'b0;
    foreach (mbuf[i]) mbuf[i] = '0;
    build_frame();
    check("zero_len", exp_bits.size(), 53);
    check("zero_crc", int'(m_crc), 0);
    run_frame(1'b1, -1);

    for (int f = 0; f < 4; f++) begin
      for (int a = 0; a < 11; a++) wr(a, int'($urandom));
      run_frame(1'($urandom_range(0, 1)), -1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
